// File: rtl/matmul_sequencer.sv
// Multi-tile job scheduler for the 2x2 systolic datapath: per tile it loads weights and inputs,
// streams valid until the accumulators fill, stores the result, then issues one final ext readout.
module matmul_sequencer #(
    parameter int ADDR_W     = 13,
    parameter int TILE_W     = 4,
    parameter int W_STRIDE   = 4,
    parameter int IN_STRIDE  = 4,
    parameter int OUT_STRIDE = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic              acc_full,
    output logic              load_weight,
    output logic              load_input,
    output logic              valid,
    output logic              store,
    output logic              ext,
    output logic [ADDR_W-1:0] base_address,
    output logic [TILE_W-1:0] tile_idx,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_IN = 3'd2,
        COMPUTE = 3'd3,
        STORE   = 3'd4,
        EXT     = 3'd5,
        FIN     = 3'd6
    } state_t;

    state_t state, next_state;

    logic [TILE_W-1:0] ntiles_q, ntiles_sel;
    logic [ADDR_W-1:0] w_q, in_q, out_q;
    logic [ADDR_W-1:0] w_sel, in_sel, out_sel;
    logic [TILE_W-1:0] tile, tile_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              err_n, latch, zero_done, in_job;

    logic              load_weight_n, load_input_n, valid_n, store_n, ext_n, busy_n, done_n;
    logic [ADDR_W-1:0] addr_n;

    assign fsm_state = state;
    assign tile_idx  = tile;
    assign in_job    = (state == LOAD_W) || (state == LOAD_IN) || (state == COMPUTE) ||
                       (state == STORE)  || (state == EXT);

    always_comb begin
        next_state = state;
        tile_n     = tile;
        cnt_n      = cnt;
        err_n      = err;
        latch      = 1'b0;
        zero_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    err_n = 1'b0;
                    if (num_tiles != '0) begin
                        latch      = 1'b1;
                        tile_n     = '0;
                        next_state = LOAD_W;
                    end else begin
                        zero_done = 1'b1;
                    end
                end
            end
            LOAD_W:  next_state = LOAD_IN;
            LOAD_IN: begin
                cnt_n      = '0;
                next_state = COMPUTE;
            end
            COMPUTE: begin
                cnt_n = cnt + CNT_W'(1);
                // A fill on the final allowed cycle still counts as success.
                if (acc_full) begin
                    next_state = STORE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_n      = 1'b1;
                    next_state = FIN;
                end
            end
            STORE: begin
                if (tile == ntiles_q - TILE_W'(1)) begin
                    next_state = EXT;
                end else begin
                    tile_n     = tile + TILE_W'(1);
                    next_state = LOAD_W;
                end
            end
            EXT:     next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort && in_job) begin
            next_state = IDLE;
            tile_n     = tile;
            cnt_n      = cnt;
            err_n      = err;
        end
    end

    // Address for the entering state uses the freshly latched config on the start edge.
    assign ntiles_sel = latch ? num_tiles : ntiles_q;
    assign w_sel      = latch ? w_base    : w_q;
    assign in_sel     = latch ? in_base   : in_q;
    assign out_sel    = latch ? out_base  : out_q;

    always_comb begin
        load_weight_n = 1'b0;
        load_input_n  = 1'b0;
        valid_n       = 1'b0;
        store_n       = 1'b0;
        ext_n         = 1'b0;
        busy_n        = 1'b0;
        addr_n        = '0;
        case (next_state)
            LOAD_W: begin
                load_weight_n = 1'b1;
                busy_n        = 1'b1;
                addr_n        = w_sel + ADDR_W'(tile_n) * ADDR_W'(W_STRIDE);
            end
            LOAD_IN: begin
                load_input_n = 1'b1;
                busy_n       = 1'b1;
                addr_n       = in_sel + ADDR_W'(tile_n) * ADDR_W'(IN_STRIDE);
            end
            COMPUTE: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                addr_n  = in_sel + ADDR_W'(tile_n) * ADDR_W'(IN_STRIDE);
            end
            STORE: begin
                store_n = 1'b1;
                busy_n  = 1'b1;
                addr_n  = out_sel + ADDR_W'(tile_n) * ADDR_W'(OUT_STRIDE);
            end
            EXT: begin
                ext_n  = 1'b1;
                busy_n = 1'b1;
                addr_n = out_sel;
            end
            default: ;
        endcase
        done_n = (next_state == FIN) || zero_done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ntiles_q     <= '0;
            w_q          <= '0;
            in_q         <= '0;
            out_q        <= '0;
            tile         <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            valid        <= 1'b0;
            store        <= 1'b0;
            ext          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            base_address <= '0;
        end else begin
            state        <= next_state;
            ntiles_q     <= ntiles_sel;
            w_q          <= w_sel;
            in_q         <= in_sel;
            out_q        <= out_sel;
            tile         <= tile_n;
            cnt          <= cnt_n;
            err          <= err_n;
            load_weight  <= load_weight_n;
            load_input   <= load_input_n;
            valid        <= valid_n;
            store        <= store_n;
            ext          <= ext_n;
            busy         <= busy_n;
            done         <= done_n;
            base_address <= addr_n;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: table of whole jobs with hand-computed summaries, plus
// hand-written sequences for the cycle trace, zero-tile, timeout, abort and async reset cases.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, abort, acc_full;
    logic [3:0]  num_tiles;
    logic [12:0] w_base, in_base, out_base;
    logic        load_weight, load_input, valid, store, ext, busy, done, err;
    logic [12:0] base_address;
    logic [3:0]  tile_idx;
    logic [2:0]  fsm_state;

    int checks = 0;
    int passes = 0;

    matmul_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_tiles(num_tiles),
        .w_base(w_base), .in_base(in_base), .out_base(out_base), .acc_full(acc_full),
        .load_weight(load_weight), .load_input(load_input), .valid(valid), .store(store),
        .ext(ext), .base_address(base_address), .tile_idx(tile_idx), .busy(busy),
        .done(done), .err(err), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  nt;
        logic [12:0] wb, ib, ob;
        int          lat;
        int          exp_valid, exp_busy;
        logic [12:0] exp_first_lw, exp_last_lw, exp_last_st;
    } job_t;

    job_t jobs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // {load_weight, load_input, valid, store, ext, busy, done, base_address}
    function automatic logic [19:0] outs();
        return {load_weight, load_input, valid, store, ext, busy, done, base_address};
    endfunction

    task automatic run_job(input job_t j, input int idx);
        int n_lw = 0, n_li = 0, n_v = 0, n_st = 0, n_ext = 0, n_busy = 0, n_done = 0, vcnt = 0;
        logic [12:0] first_lw = '0, last_lw = '0, last_st = '0, ext_addr = '1;
        logic [3:0]  last_tile = '0;
        bit          got_first = 0;
        @(negedge clk);
        num_tiles = j.nt; w_base = j.wb; in_base = j.ib; out_base = j.ob; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_tiles = 4'hF; w_base = 13'h1555; in_base = 13'h0AAA; out_base = 13'h1234;
        check($sformatf("job%0d_latency_lw", idx), {31'b0, load_weight}, 32'd1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (load_weight) begin
                n_lw++;
                if (!got_first) first_lw = base_address;
                got_first = 1;
                last_lw = base_address;
            end
            if (load_input) n_li++;
            if (valid) begin n_v++; vcnt++; end
            if (store) begin n_st++; last_st = base_address; last_tile = tile_idx; vcnt = 0; end
            if (ext) begin n_ext++; ext_addr = base_address; end
            if (busy) n_busy++;
            if (done) n_done++;
            acc_full = valid && (vcnt == j.lat);
            if (done) break;
            @(negedge clk);
        end
        acc_full = 1'b0;
        check($sformatf("job%0d_err", idx), {31'b0, err}, 32'd0);
        check($sformatf("job%0d_done_cnt", idx), n_done, 32'd1);
        check($sformatf("job%0d_lw_cnt", idx), n_lw, 32'(j.nt));
        check($sformatf("job%0d_li_cnt", idx), n_li, 32'(j.nt));
        check($sformatf("job%0d_st_cnt", idx), n_st, 32'(j.nt));
        check($sformatf("job%0d_ext_cnt", idx), n_ext, 32'd1);
        check($sformatf("job%0d_valid_cnt", idx), n_v, j.exp_valid);
        check($sformatf("job%0d_busy_cnt", idx), n_busy, j.exp_busy);
        check($sformatf("job%0d_first_lw", idx), {19'b0, first_lw}, {19'b0, j.exp_first_lw});
        check($sformatf("job%0d_last_lw", idx), {19'b0, last_lw}, {19'b0, j.exp_last_lw});
        check($sformatf("job%0d_last_st", idx), {19'b0, last_st}, {19'b0, j.exp_last_st});
        check($sformatf("job%0d_ext_addr", idx), {19'b0, ext_addr}, {19'b0, j.ob});
        check($sformatf("job%0d_last_tile", idx), {28'b0, last_tile}, 32'(j.nt - 4'd1));
        @(negedge clk);
        check($sformatf("job%0d_done_1cyc", idx), {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [19:0] exp_trace[9];
        int          n_v, n_bad;
        bit          seen;

        jobs[0] = '{nt: 4'd1,  wb: 13'h010,  ib: 13'h020, ob: 13'h030,  lat: 3,
                    exp_valid: 3,  exp_busy: 7,  exp_first_lw: 13'h010,  exp_last_lw: 13'h010, exp_last_st: 13'h030};
        jobs[1] = '{nt: 4'd3,  wb: 13'h010,  ib: 13'h020, ob: 13'h030,  lat: 3,
                    exp_valid: 9,  exp_busy: 19, exp_first_lw: 13'h010,  exp_last_lw: 13'h018, exp_last_st: 13'h038};
        jobs[2] = '{nt: 4'd2,  wb: 13'h1FFE, ib: 13'h100, ob: 13'h1FFC, lat: 1,
                    exp_valid: 2,  exp_busy: 9,  exp_first_lw: 13'h1FFE, exp_last_lw: 13'h0002, exp_last_st: 13'h0000};
        jobs[3] = '{nt: 4'd15, wb: 13'h000,  ib: 13'h200, ob: 13'h400,  lat: 2,
                    exp_valid: 30, exp_busy: 76, exp_first_lw: 13'h000,  exp_last_lw: 13'h038, exp_last_st: 13'h438};
        jobs[4] = '{nt: 4'd2,  wb: 13'h100,  ib: 13'h200, ob: 13'h300,  lat: 16,
                    exp_valid: 32, exp_busy: 39, exp_first_lw: 13'h100,  exp_last_lw: 13'h104, exp_last_st: 13'h304};

        exp_trace[0] = {7'b1000010, 13'h010};
        exp_trace[1] = {7'b0100010, 13'h020};
        exp_trace[2] = {7'b0010010, 13'h020};
        exp_trace[3] = {7'b0010010, 13'h020};
        exp_trace[4] = {7'b0010010, 13'h020};
        exp_trace[5] = {7'b0001010, 13'h030};
        exp_trace[6] = {7'b0000110, 13'h030};
        exp_trace[7] = {7'b0000001, 13'h000};
        exp_trace[8] = {7'b0000000, 13'h000};

        reset = 1'b0; start = 1'b0; abort = 1'b0; acc_full = 1'b0;
        num_tiles = '0; w_base = '0; in_base = '0; out_base = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {11'b0, outs()}, 32'd0);
        check("reset_err_tile", {27'b0, err, tile_idx}, 32'd0);
        reset = 1'b1;

        // Cycle-exact trace of a single-tile job.
        @(negedge clk);
        num_tiles = 4'd1; w_base = 13'h010; in_base = 13'h020; out_base = 13'h030; start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("trace_c%0d", i), {12'b0, outs()}, {12'b0, exp_trace[i]});
            acc_full = (i == 4);
        end
        acc_full = 1'b0;

        for (int i = 0; i < 5; i++) run_job(jobs[i], i);

        // Zero-tile job: one done pulse, nothing else.
        @(negedge clk);
        num_tiles = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", {12'b0, outs()}, {12'b0, 7'b0000001, 13'h000});
        n_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (load_weight || load_input || valid || store || ext || busy || done) n_bad++;
        end
        check("zero_quiet", n_bad, 32'd0);

        // Timeout: acc_full never rises.
        @(negedge clk);
        num_tiles = 4'd1; w_base = 13'h010; in_base = 13'h020; out_base = 13'h030; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_v = 0; seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (valid) n_v++;
            if (done) begin seen = 1; break; end
            @(negedge clk);
        end
        check("to_done_seen", {31'b0, seen}, 32'd1);
        check("to_valid_cnt", n_v, 32'd16);
        check("to_err_with_done", {31'b0, err}, 32'd1);
        @(negedge clk);
        check("to_err_sticky", {30'b0, err, busy}, 32'd2);
        num_tiles = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("to_err_cleared", {30'b0, err, done}, 32'd1);

        // Abort on the second compute cycle of tile 1, with a start pulse during tile 0.
        @(negedge clk);
        num_tiles = 4'd3; w_base = 13'h010; in_base = 13'h020; out_base = 13'h030; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_v = 0; seen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            start = 1'b0;
            if (valid) n_v++;
            if (store) n_v = 0;
            if (valid && tile_idx == 4'd0 && n_v == 1) start = 1'b1;
            if (valid && tile_idx == 4'd1 && n_v == 2) begin seen = 1; break; end
            acc_full = valid && (n_v == 3);
            @(negedge clk);
        end
        start = 1'b0; acc_full = 1'b0;
        check("abort_reached", {31'b0, seen}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outs", {11'b0, outs()}, 32'd0);
        check("abort_err", {31'b0, err}, 32'd0);
        n_bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done || ext || load_weight) n_bad++;
        end
        check("abort_no_relaunch", n_bad, 32'd0);

        // Abort together with start in IDLE launches nothing.
        num_tiles = 4'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_bad = 0;
        repeat (3) begin
            if (busy || done || load_weight) n_bad++;
            @(negedge clk);
        end
        check("abort_start_idle", n_bad, 32'd0);

        // Asynchronous reset in the middle of COMPUTE.
        num_tiles = 4'd2; w_base = 13'h040; in_base = 13'h050; out_base = 13'h060; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("areset_pre_valid", {31'b0, valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("areset_outs", {11'b0, outs()}, 32'd0);
        check("areset_err_tile", {27'b0, err, tile_idx}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("areset_idle", {11'b0, outs()}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
